// File: rtl/ctrl_pkg.sv
// Shared decode definitions: opcodes, ALU/compare/memory codes, control bundle layout, stage FSM encoding.
package ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [1:0] MEM_BYTE   = 2'd0;
  localparam logic [1:0] MEM_HALF   = 2'd1;
  localparam logic [1:0] MEM_WORD   = 2'd2;
  localparam logic [1:0] MEM_DOUBLE = 2'd3;

  localparam int CTRL_W              = 20;
  localparam int CTRL_ILL            = 0;
  localparam int CTRL_JUMP_REG       = 1;
  localparam int CTRL_JUMP_EN        = 2;
  localparam int CTRL_PC_TO_ALU      = 3;
  localparam int CTRL_PC_TO_REG      = 4;
  localparam int CTRL_ALU_SRC        = 5;
  localparam int CTRL_ALU_OP_LSB     = 6;
  localparam int CTRL_MEM_TO_REG     = 10;
  localparam int CTRL_REG_WE         = 11;
  localparam int CTRL_MEM_MODE_LSB   = 12;
  localparam int CTRL_MEM_UNSIGNED   = 14;
  localparam int CTRL_MEM_WE         = 15;
  localparam int CTRL_BRANCH_MODE_LSB = 16;
  localparam int CTRL_BRANCH_EN      = 19;

  // Field order is MSB first so the bit offsets above hold.
  typedef struct packed {
    logic       branch_en;
    logic [2:0] branch_mode;
    logic       mem_we;
    logic       mem_unsigned;
    logic [1:0] mem_mode;
    logic       reg_we;
    logic       mem_to_reg;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       pc_to_reg;
    logic       pc_to_alu;
    logic       jump_en;
    logic       jump_reg;
    logic       ill;
  } ctrl_t;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    FULL   = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  // alt selects SUB/SRA (instr[30]); callers only pass it where those exist.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I/RV64I instruction -> ctrl_t decoder, XLEN-aware.
// auipc is legal only when CTRL_AUIPC_EN is defined; otherwise it decodes as illegal.
module decode_comb
  import ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [6:0] funct7_shift;
  logic       legal;
  ctrl_t      c;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // RV64 immediate shifts use bit 25 as shamt[5].
  assign funct7_shift  = IS64 ? {instr[31:26], 1'b0} : instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    c     = '0;
    legal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        legal     = 1'b1;
        c.reg_we  = 1'b1;
        c.alu_src = 1'b1;
        c.alu_op  = ALU_PASSB;
      end
      OPC_AUIPC: begin
`ifdef CTRL_AUIPC_EN
        legal       = 1'b1;
        c.reg_we    = 1'b1;
        c.alu_src   = 1'b1;
        c.pc_to_alu = 1'b1;
        c.alu_op    = ALU_ADD;
`else
        legal = 1'b0;
`endif
      end
      OPC_JAL: begin
        legal       = 1'b1;
        c.jump_en   = 1'b1;
        c.reg_we    = 1'b1;
        c.pc_to_reg = 1'b1;
      end
      OPC_JALR: begin
        legal       = (funct3 == 3'b000);
        c.jump_en   = 1'b1;
        c.jump_reg  = 1'b1;
        c.reg_we    = 1'b1;
        c.pc_to_reg = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OPC_BRANCH: begin
        legal         = (funct3[2:1] != 2'b01);
        c.branch_en   = 1'b1;
        c.branch_mode = funct3;
        c.alu_op      = ALU_SUB;
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
          3'b011, 3'b110:                         legal = IS64;
          default:                                legal = 1'b0;
        endcase
        c.reg_we       = 1'b1;
        c.mem_to_reg   = 1'b1;
        c.alu_src      = 1'b1;
        c.alu_op       = ALU_ADD;
        c.mem_mode     = funct3[1:0];
        c.mem_unsigned = funct3[2];
      end
      OPC_STORE: begin
        legal      = (funct3[2:1] == 2'b00) || (funct3 == 3'b010) || (IS64 && funct3 == 3'b011);
        c.mem_we   = 1'b1;
        c.alu_src  = 1'b1;
        c.alu_op   = ALU_ADD;
        c.mem_mode = funct3[1:0];
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7_shift == 7'b0000000);
          3'b101:  legal = (funct7_shift == 7'b0000000) || (funct7_shift == 7'b0100000);
          default: legal = 1'b1;
        endcase
        c.reg_we  = 1'b1;
        c.alu_src = 1'b1;
        c.alu_op  = alu_from_funct(funct3, instr[30] && (funct3 == 3'b101));
      end
      OPC_OP: begin
        legal    = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && (funct3 == 3'b000 || funct3 == 3'b101));
        c.reg_we = 1'b1;
        c.alu_op = alu_from_funct(funct3, instr[30]);
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      c     = '0;
      c.ill = 1'b1;
    end
  end

  assign ctrl = c;

endmodule

// File: rtl/decode_stage.sv
// Registered ID/EX decode stage: 1-cycle accept->out latency, valid/ready both sides, one bubble per load-use pair.
// flush swallows input and empties the register; auipc support is controlled by CTRL_AUIPC_EN (see decode_comb).
module decode_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [31:0]       out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic              ill_flag,
  output logic [31:0]       ill_capture,
  input  logic              ill_clear,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      dec;
  ctrl_t      held;
  logic       uses_rs2;
  logic [4:0] held_rd;
  logic       hazard;
  logic       accept;
  logic       fire;

  decode_comb #(.XLEN(XLEN)) u_decode_comb (
    .instr (in_instr),
    .ctrl  (dec)
  );

  assign uses_rs2 = (in_instr[6:0] == OPC_OP) || (in_instr[6:0] == OPC_BRANCH) ||
                    (in_instr[6:0] == OPC_STORE);
  assign held_rd  = out_instr[11:7];
  assign hazard   = (state == FULL) && held.mem_to_reg && (held_rd != 5'd0) && in_valid &&
                    ((in_instr[19:15] == held_rd) || (uses_rs2 && in_instr[24:20] == held_rd));
  assign accept   = in_valid && in_ready && !flush;
  assign fire     = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:  if (accept) state_nxt = FULL;
        FULL: begin
          if (hazard && out_ready)  state_nxt = BUBBLE;
          else if (fire && !accept) state_nxt = EMPTY;
        end
        BUBBLE: state_nxt = accept ? FULL : EMPTY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = flush || (!hazard && ((state != FULL) || out_ready));
  end

  // The register only loads on accept, which keeps out_* stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held      <= '0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (accept) begin
      held      <= dec;
      out_instr <= in_instr;
      out_pc    <= in_pc;
    end
  end

  assign out_ctrl = held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_flag    <= 1'b0;
      ill_capture <= '0;
    end else if (ill_clear) begin
      ill_flag    <= 1'b0;
      ill_capture <= '0;
    end else if (accept && dec.ill && !ill_flag) begin
      ill_flag    <= 1'b1;
      ill_capture <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, directed pipeline sequences, random traffic vs a transaction model.
module tb_decode_stage;
  import ctrl_pkg::*;

  localparam int TB_XLEN  = 32;
  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [TB_XLEN-1:0]  in_pc;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [CTRL_W-1:0]   out_ctrl;
  logic [31:0]         out_instr;
  logic [TB_XLEN-1:0]  out_pc;
  logic                ill_flag;
  logic [31:0]         ill_capture;
  logic                ill_clear;
  logic [TB_CNT_W-1:0] stall_cnt;

  decode_stage #(.XLEN(TB_XLEN), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_instr(out_instr), .out_pc(out_pc), .ill_flag(ill_flag),
    .ill_capture(ill_capture), .ill_clear(ill_clear), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ISA pattern table (mask/match), the reference for what each legal encoding must produce.
  typedef struct { logic [31:0] mask; logic [31:0] match; ctrl_t c; } pat_t;
  pat_t pats[$];

  function automatic ctrl_t k_alu(input logic [3:0] op, input logic src);
    ctrl_t c = '0;
    c.alu_op = op; c.alu_src = src; c.reg_we = 1'b1;
    return c;
  endfunction
  function automatic ctrl_t k_ld(input logic [1:0] m, input logic u);
    ctrl_t c = k_alu(ALU_ADD, 1'b1);
    c.mem_to_reg = 1'b1; c.mem_mode = m; c.mem_unsigned = u;
    return c;
  endfunction
  function automatic ctrl_t k_st(input logic [1:0] m);
    ctrl_t c = '0;
    c.alu_src = 1'b1; c.mem_we = 1'b1; c.mem_mode = m;
    return c;
  endfunction
  function automatic ctrl_t k_br(input logic [2:0] m);
    ctrl_t c = '0;
    c.branch_en = 1'b1; c.branch_mode = m; c.alu_op = ALU_SUB;
    return c;
  endfunction

  task automatic add_pat(input logic [31:0] mask, input logic [31:0] match, input ctrl_t c);
    pat_t p;
    p.mask = mask; p.match = match; p.c = c;
    pats.push_back(p);
  endtask

  task automatic build_pats();
    ctrl_t c;
    logic [31:0] shm;
    shm = (TB_XLEN == 64) ? 32'hFC00707F : 32'hFE00707F;
    add_pat(32'h7F, 32'h37, k_alu(ALU_PASSB, 1'b1));
`ifdef CTRL_AUIPC_EN
    c = k_alu(ALU_ADD, 1'b1); c.pc_to_alu = 1'b1;
    add_pat(32'h7F, 32'h17, c);
`endif
    c = '0; c.jump_en = 1'b1; c.reg_we = 1'b1; c.pc_to_reg = 1'b1;
    add_pat(32'h7F, 32'h6F, c);
    c = k_alu(ALU_ADD, 1'b1); c.jump_en = 1'b1; c.jump_reg = 1'b1; c.pc_to_reg = 1'b1;
    add_pat(32'h707F, 32'h67, c);
    add_pat(32'h707F, 32'h0063, k_br(BR_EQ));
    add_pat(32'h707F, 32'h1063, k_br(BR_NE));
    add_pat(32'h707F, 32'h4063, k_br(BR_LT));
    add_pat(32'h707F, 32'h5063, k_br(BR_GE));
    add_pat(32'h707F, 32'h6063, k_br(BR_LTU));
    add_pat(32'h707F, 32'h7063, k_br(BR_GEU));
    add_pat(32'h707F, 32'h0003, k_ld(MEM_BYTE, 1'b0));
    add_pat(32'h707F, 32'h1003, k_ld(MEM_HALF, 1'b0));
    add_pat(32'h707F, 32'h2003, k_ld(MEM_WORD, 1'b0));
    add_pat(32'h707F, 32'h4003, k_ld(MEM_BYTE, 1'b1));
    add_pat(32'h707F, 32'h5003, k_ld(MEM_HALF, 1'b1));
    add_pat(32'h707F, 32'h0023, k_st(MEM_BYTE));
    add_pat(32'h707F, 32'h1023, k_st(MEM_HALF));
    add_pat(32'h707F, 32'h2023, k_st(MEM_WORD));
    if (TB_XLEN == 64) begin
      add_pat(32'h707F, 32'h3003, k_ld(MEM_DOUBLE, 1'b0));
      add_pat(32'h707F, 32'h6003, k_ld(MEM_WORD, 1'b1));
      add_pat(32'h707F, 32'h3023, k_st(MEM_DOUBLE));
    end
    add_pat(32'h707F, 32'h0013, k_alu(ALU_ADD, 1'b1));
    add_pat(32'h707F, 32'h2013, k_alu(ALU_SLT, 1'b1));
    add_pat(32'h707F, 32'h3013, k_alu(ALU_SLTU, 1'b1));
    add_pat(32'h707F, 32'h4013, k_alu(ALU_XOR, 1'b1));
    add_pat(32'h707F, 32'h6013, k_alu(ALU_OR, 1'b1));
    add_pat(32'h707F, 32'h7013, k_alu(ALU_AND, 1'b1));
    add_pat(shm, 32'h00001013, k_alu(ALU_SLL, 1'b1));
    add_pat(shm, 32'h00005013, k_alu(ALU_SRL, 1'b1));
    add_pat(shm, 32'h40005013, k_alu(ALU_SRA, 1'b1));
    add_pat(32'hFE00707F, 32'h00000033, k_alu(ALU_ADD, 1'b0));
    add_pat(32'hFE00707F, 32'h40000033, k_alu(ALU_SUB, 1'b0));
    add_pat(32'hFE00707F, 32'h00001033, k_alu(ALU_SLL, 1'b0));
    add_pat(32'hFE00707F, 32'h00002033, k_alu(ALU_SLT, 1'b0));
    add_pat(32'hFE00707F, 32'h00003033, k_alu(ALU_SLTU, 1'b0));
    add_pat(32'hFE00707F, 32'h00004033, k_alu(ALU_XOR, 1'b0));
    add_pat(32'hFE00707F, 32'h00005033, k_alu(ALU_SRL, 1'b0));
    add_pat(32'hFE00707F, 32'h40005033, k_alu(ALU_SRA, 1'b0));
    add_pat(32'hFE00707F, 32'h00006033, k_alu(ALU_OR, 1'b0));
    add_pat(32'hFE00707F, 32'h00007033, k_alu(ALU_AND, 1'b0));
  endtask

  function automatic ctrl_t ref_decode(input logic [31:0] ins);
    ctrl_t c;
    for (int k = 0; k < pats.size(); k++)
      if ((ins & pats[k].mask) == pats[k].match) return pats[k].c;
    c = '0; c.ill = 1'b1;
    return c;
  endfunction

  function automatic logic reads_rs2(input logic [31:0] ins);
    return (ins[6:0] == 7'h33) || (ins[6:0] == 7'h63) || (ins[6:0] == 7'h23);
  endfunction

  // Transaction model: one optional held instruction plus status.
  logic                m_have;
  logic [31:0]         m_instr;
  logic [TB_XLEN-1:0]  m_pc;
  logic                m_ill_flag;
  logic [31:0]         m_ill_cap;
  logic [TB_CNT_W-1:0] m_stall;
  logic                last_in_ready;

  task automatic model_reset();
    m_have = 1'b0; m_instr = '0; m_pc = '0;
    m_ill_flag = 1'b0; m_ill_cap = '0; m_stall = '0;
  endtask

  // Called at posedge+1; drives, checks at negedge, then advances to the next posedge+1.
  task automatic step(input logic v, input logic [31:0] ins, input logic [TB_XLEN-1:0] pc,
                      input logic ordy, input logic fl, input logic clr);
    logic hz, exp_rdy, acc;
    logic [4:0] rd;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl; ill_clear = clr;
    @(negedge clk);
    rd = m_instr[11:7];
    hz = m_have && ref_decode(m_instr).mem_to_reg && (rd != 5'd0) && v &&
         ((ins[19:15] == rd) || (reads_rs2(ins) && ins[24:20] == rd));
    exp_rdy = fl || (!hz && (!m_have || ordy));
    last_in_ready = in_ready;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_have));
    if (m_have) begin
      chk("out_instr", 64'(out_instr), 64'(m_instr));
      chk("out_pc", 64'(out_pc), 64'(m_pc));
      chk("out_ctrl", 64'(out_ctrl), 64'(ref_decode(m_instr)));
    end
    chk("ill_flag", 64'(ill_flag), 64'(m_ill_flag));
    chk("ill_capture", 64'(ill_capture), 64'(m_ill_cap));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    acc = v && exp_rdy && !fl;
    if (hz && (m_stall != '1)) m_stall = m_stall + 1'b1;
    if (clr) begin
      m_ill_flag = 1'b0; m_ill_cap = '0;
    end else if (acc && ref_decode(ins).ill && !m_ill_flag) begin
      m_ill_flag = 1'b1; m_ill_cap = ins;
    end
    if (fl)                  m_have = 1'b0;
    else if (acc)            begin m_have = 1'b1; m_instr = ins; m_pc = pc; end
    else if (m_have && ordy) m_have = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_we;
    logic [1:0]  mem_mode;
    logic        mem_we;
    logic        mem_to_reg;
    logic        branch_en;
    logic        jump_en;
    logic        pc_to_alu;
  } vec_t;
  vec_t vecs[12];

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_ADD   = 32'h001101B3;
  localparam logic [31:0] I_SUB   = 32'h401101B3;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_LD    = 32'h0000B103;
  localparam logic [31:0] I_AUIPC = 32'h00001297;
  localparam logic [31:0] I_BAD   = 32'hFFFFFFFF;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_t oc;
    logic [31:0] ins;
    logic [31:0] held_instr;
    int k;

    build_pats();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0; ill_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_ill_flag", 64'(ill_flag), 64'd0);
    rst = 1'b0;

    // 1: back-to-back addi, add
    step(1'b1, I_ADDI, 32'h100, 1'b1, 1'b0, 1'b0);
    oc = ctrl_t'(out_ctrl);
    chk("t1_addi_valid", 64'(out_valid), 64'd1);
    chk("t1_addi_alu", 64'(oc.alu_op), 64'(ALU_ADD));
    chk("t1_addi_src", 64'(oc.alu_src), 64'd1);
    step(1'b1, I_ADD, 32'h104, 1'b1, 1'b0, 1'b0);
    oc = ctrl_t'(out_ctrl);
    chk("t1_add_valid", 64'(out_valid), 64'd1);
    chk("t1_add_instr", 64'(out_instr), 64'(I_ADD));
    chk("t1_add_src", 64'(oc.alu_src), 64'd0);
    chk("t1_add_we", 64'(oc.reg_we), 64'd1);
    idle();
    chk("t1_stall", 64'(stall_cnt), 64'd0);

    // 2: load-use costs one bubble
    step(1'b1, I_LW, 32'h200, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_ADD, 32'h204, 1'b1, 1'b0, 1'b0);
    chk("t2_in_ready_low", 64'(last_in_ready), 64'd0);
    chk("t2_gap", 64'(out_valid), 64'd0);
    chk("t2_stall_one", 64'(stall_cnt), 64'd1);
    step(1'b1, I_ADD, 32'h204, 1'b1, 1'b0, 1'b0);
    chk("t2_add_after_lw", 64'(out_instr), 64'(I_ADD));
    chk("t2_add_valid", 64'(out_valid), 64'd1);
    idle();

    // 3: backpressure for three cycles
    step(1'b1, I_ADDI, 32'h300, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, I_SUB, 32'h304, 1'b0, 1'b0, 1'b0);
      chk("t3_hold_instr", 64'(out_instr), 64'(I_ADDI));
      chk("t3_hold_pc", 64'(out_pc), 64'h300);
      chk("t3_in_ready_low", 64'(last_in_ready), 64'd0);
    end
    step(1'b1, I_SUB, 32'h304, 1'b1, 1'b0, 1'b0);
    chk("t3_next_follows", 64'(out_instr), 64'(I_SUB));
    idle();

    // 4: flush while full with input pending
    step(1'b1, I_ADDI, 32'h400, 1'b1, 1'b0, 1'b0);
    step(1'b1, I_ADD, 32'h404, 1'b0, 1'b1, 1'b0);
    chk("t4_flush_ready", 64'(last_in_ready), 64'd1);
    chk("t4_flush_empty", 64'(out_valid), 64'd0);
    step(1'b1, I_SUB, 32'h500, 1'b1, 1'b0, 1'b0);
    chk("t4_after_flush", 64'(out_instr), 64'(I_SUB));
    chk("t4_after_pc", 64'(out_pc), 64'h500);
    idle();

    // 5: ld legality and illegal status
    step(1'b1, I_LD, 32'h600, 1'b1, 1'b0, 1'b0);
    oc = ctrl_t'(out_ctrl);
    if (TB_XLEN == 64) begin
      chk("t5_ld_mode", 64'(oc.mem_mode), 64'(MEM_DOUBLE));
      chk("t5_ld_flag", 64'(ill_flag), 64'd0);
    end else begin
      chk("t5_ld_ill", 64'(oc.ill), 64'd1);
      chk("t5_ld_flag", 64'(ill_flag), 64'd1);
      chk("t5_ld_capture", 64'(ill_capture), 64'h0000B103);
    end
    step(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b1);
    chk("t5_clear_flag", 64'(ill_flag), 64'd0);
    chk("t5_clear_capture", 64'(ill_capture), 64'd0);
    step(1'b1, I_BAD, 32'h604, 1'b1, 1'b0, 1'b1);
    chk("t5_clear_wins_flag", 64'(ill_flag), 64'd0);
    chk("t5_clear_wins_cap", 64'(ill_capture), 64'd0);
    idle();

    // 6: auipc
    step(1'b1, I_AUIPC, 32'h700, 1'b1, 1'b0, 1'b0);
    oc = ctrl_t'(out_ctrl);
`ifdef CTRL_AUIPC_EN
    chk("t6_auipc_pc_to_alu", 64'(oc.pc_to_alu), 64'd1);
    chk("t6_auipc_alu", 64'(oc.alu_op), 64'(ALU_ADD));
    chk("t6_auipc_we", 64'(oc.reg_we), 64'd1);
`else
    chk("t6_auipc_ill", 64'(oc.ill), 64'd1);
    chk("t6_auipc_we", 64'(oc.reg_we), 64'd0);
    chk("t6_auipc_capture", 64'(ill_capture), 64'(I_AUIPC));
`endif
    step(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b1);

    // Decode vector table
    vecs[0]  = '{I_ADDI,       1'b0, ALU_ADD,   1'b1, 1'b1, MEM_BYTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{I_ADD,        1'b0, ALU_ADD,   1'b0, 1'b1, MEM_BYTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{I_SUB,        1'b0, ALU_SUB,   1'b0, 1'b1, MEM_BYTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{I_LW,         1'b0, ALU_ADD,   1'b1, 1'b1, MEM_WORD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h0020A023, 1'b0, ALU_ADD,   1'b1, 1'b0, MEM_WORD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h00208063, 1'b0, ALU_SUB,   1'b0, 1'b0, MEM_BYTE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h000000EF, 1'b0, ALU_ADD,   1'b0, 1'b1, MEM_BYTE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h000012B7, 1'b0, ALU_PASSB, 1'b1, 1'b1, MEM_BYTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{I_BAD,        1'b1, ALU_ADD,   1'b0, 1'b0, MEM_BYTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if (TB_XLEN == 64) begin
      vecs[9]  = '{I_LD,         1'b0, ALU_ADD, 1'b1, 1'b1, MEM_DOUBLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'h02009093, 1'b0, ALU_SLL, 1'b1, 1'b1, MEM_BYTE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end else begin
      vecs[9]  = '{I_LD,         1'b1, ALU_ADD, 1'b0, 1'b0, MEM_BYTE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'h02009093, 1'b1, ALU_ADD, 1'b0, 1'b0, MEM_BYTE,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    end
`ifdef CTRL_AUIPC_EN
    vecs[11] = '{I_AUIPC, 1'b0, ALU_ADD, 1'b1, 1'b1, MEM_BYTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    vecs[11] = '{I_AUIPC, 1'b1, ALU_ADD, 1'b0, 1'b0, MEM_BYTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int v = 0; v < 12; v++) begin
      step(1'b1, vecs[v].instr, TB_XLEN'(32'h800 + 4 * v), 1'b1, 1'b0, 1'b0);
      oc = ctrl_t'(out_ctrl);
      chk($sformatf("vec%0d_ill", v), 64'(oc.ill), 64'(vecs[v].ill));
      chk($sformatf("vec%0d_alu_op", v), 64'(oc.alu_op), 64'(vecs[v].alu_op));
      chk($sformatf("vec%0d_alu_src", v), 64'(oc.alu_src), 64'(vecs[v].alu_src));
      chk($sformatf("vec%0d_reg_we", v), 64'(oc.reg_we), 64'(vecs[v].reg_we));
      chk($sformatf("vec%0d_mem_mode", v), 64'(oc.mem_mode), 64'(vecs[v].mem_mode));
      chk($sformatf("vec%0d_mem_we", v), 64'(oc.mem_we), 64'(vecs[v].mem_we));
      chk($sformatf("vec%0d_mem_to_reg", v), 64'(oc.mem_to_reg), 64'(vecs[v].mem_to_reg));
      chk($sformatf("vec%0d_branch_en", v), 64'(oc.branch_en), 64'(vecs[v].branch_en));
      chk($sformatf("vec%0d_jump_en", v), 64'(oc.jump_en), 64'(vecs[v].jump_en));
      chk($sformatf("vec%0d_pc_to_alu", v), 64'(oc.pc_to_alu), 64'(vecs[v].pc_to_alu));
      idle();
    end
    step(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b1);

    // Random traffic with small register numbers so load-use pairs are frequent
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ins = $urandom;
      end else begin
        k = $urandom_range(0, pats.size() - 1);
        ins = pats[k].match | ($urandom & ~pats[k].mask);
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
      end
      step($urandom_range(0, 9) < 7, ins, TB_XLEN'($urandom), $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    end
    idle();

    // Stall counter saturation while a load is held under backpressure
    step(1'b1, I_LW, 32'h900, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, I_ADD, 32'h904, 1'b0, 1'b0, 1'b0);
    chk("sat_stall", 64'(stall_cnt), 64'hF);
    held_instr = out_instr;
    chk("sat_held", 64'(held_instr), 64'(I_LW));
    step(1'b1, I_BAD, 32'h908, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_flag", 64'(ill_flag), 64'd1);

    // Asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("arst_out_instr", 64'(out_instr), 64'd0);
    chk("arst_out_pc", 64'(out_pc), 64'd0);
    chk("arst_ill_flag", 64'(ill_flag), 64'd0);
    chk("arst_ill_capture", 64'(ill_capture), 64'd0);
    chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b1, I_ADDI, 32'hA00, 1'b1, 1'b0, 1'b0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
